// File: rtl/johnson_decoder_module_pkg.sv
// Shared constants, types and widths for the Johnson (twisted-ring) code decoder.
package johnson_decoder_module_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned RUN_W   = 3;
    localparam int unsigned CNT_W   = 8;

    // Legal 4-bit Johnson states in phase order 0..7
    localparam logic [CODE_W-1:0] CODE_PH0 = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_PH1 = 4'b0001;
    localparam logic [CODE_W-1:0] CODE_PH2 = 4'b0011;
    localparam logic [CODE_W-1:0] CODE_PH3 = 4'b0111;
    localparam logic [CODE_W-1:0] CODE_PH4 = 4'b1111;
    localparam logic [CODE_W-1:0] CODE_PH5 = 4'b1110;
    localparam logic [CODE_W-1:0] CODE_PH6 = 4'b1100;
    localparam logic [CODE_W-1:0] CODE_PH7 = 4'b1000;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic               legal;
        logic [PHASE_W-1:0] phase;
    } dec_t;

endpackage : johnson_decoder_module_pkg

// File: rtl/johnson_decoder_module_if.sv
// Sample input and decoded status bundle between a code source and the decoder.
interface johnson_decoder_module_if;
    import johnson_decoder_module_pkg::*;

    logic               in_valid;
    logic [CODE_W-1:0]  code;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               locked;
    logic               error;
    logic [CNT_W-1:0]   err_count;

    modport master (
        output in_valid,
        output code,
        input  phase,
        input  phase_valid,
        input  locked,
        input  error,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  code,
        output phase,
        output phase_valid,
        output locked,
        output error,
        output err_count
    );

endinterface : johnson_decoder_module_if

// File: rtl/johnson_decoder_module_decode.sv
// Combinational map from a 4-bit Johnson code to {legal, phase}.
module johnson_code_decode_module
    import johnson_decoder_module_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output dec_t              dec_c_o
);

    always_comb begin
        dec_c_o = '{legal: 1'b0, phase: '0};
        case (code_i)
            CODE_PH0: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(0)};
            CODE_PH1: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(1)};
            CODE_PH2: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(2)};
            CODE_PH3: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(3)};
            CODE_PH4: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(4)};
            CODE_PH5: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(5)};
            CODE_PH6: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(6)};
            CODE_PH7: dec_c_o = '{legal: 1'b1, phase: PHASE_W'(7)};
            default:  dec_c_o = '{legal: 1'b0, phase: '0};
        endcase
    end

endmodule : johnson_code_decode_module

// File: rtl/johnson_decoder_module.sv
// Johnson-code sequence tracker: decodes phase, locks after LOCK_COUNT in-order
// steps, and flags illegal or out-of-sequence samples with a saturating tally.
module johnson_decoder_module
    import johnson_decoder_module_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    johnson_decoder_module_if.slave  bus
);

    state_e             state_q, state_d;
    logic               has_ref_q, has_ref_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               phase_valid_q, phase_valid_d;
    logic               locked_q, locked_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    dec_t               dec;
    logic [PHASE_W-1:0] expected_phase;
    logic [RUN_W-1:0]   run_inc;
    logic [CNT_W-1:0]   err_count_sat;
    logic               in_seq;

    johnson_code_decode_module u_decode (
        .code_i  (bus.code),
        .dec_c_o (dec)
    );

    // The reference phase is always the last legal sample, so phase_q doubles as it.
    assign expected_phase = PHASE_W'(phase_q + PHASE_W'(1));
    assign run_inc        = RUN_W'(run_q + RUN_W'(1));
    assign err_count_sat  = (err_count_q == {CNT_W{1'b1}}) ? err_count_q
                                                            : CNT_W'(err_count_q + CNT_W'(1));
    assign in_seq         = has_ref_q && (dec.phase == expected_phase);

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        has_ref_d     = has_ref_q;
        run_d         = run_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        error_d       = 1'b0;
        err_count_d   = err_count_q;

        if (bus.in_valid) begin
            if (!dec.legal) begin
                error_d     = 1'b1;
                err_count_d = err_count_sat;
                has_ref_d   = 1'b0;
                run_d       = '0;
                state_d     = HUNT;
            end else begin
                phase_valid_d = 1'b1;
                phase_d       = dec.phase;
                has_ref_d     = 1'b1;
                case (state_q)
                    HUNT: begin
                        if (in_seq) begin
                            run_d = run_inc;
                            if (run_inc == RUN_W'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!in_seq) begin
                            error_d     = 1'b1;
                            err_count_d = err_count_sat;
                            run_d       = '0;
                            state_d     = HUNT;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                        run_d   = '0;
                    end
                endcase
            end
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            has_ref_q     <= 1'b0;
            run_q         <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            error_q       <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            has_ref_q     <= has_ref_d;
            run_q         <= run_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            locked_q      <= locked_d;
            error_q       <= error_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = locked_q;
    assign bus.error       = error_q;
    assign bus.err_count   = err_count_q;

endmodule : johnson_decoder_module

// File: tb/tb_johnson_decoder_module.sv
// Scoreboard bench: driver pushes model expectations per cycle, monitor pops and compares.
module tb_johnson_decoder_module;

    localparam int unsigned LOCK_COUNT = 2;

    typedef struct packed {
        logic [2:0] phase;
        logic       pv;
        logic       locked;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    johnson_decoder_module_if bus ();

    johnson_decoder_module #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: ring of eight legal codes, position = phase
    logic [3:0] ring [8];
    logic [3:0] bad_codes [8];
    int  m_ref, m_run, m_errs, m_phase;
    bit  m_has_ref, m_locked;

    initial begin
        ring[0] = 4'b0000; ring[1] = 4'b0001; ring[2] = 4'b0011; ring[3] = 4'b0111;
        ring[4] = 4'b1111; ring[5] = 4'b1110; ring[6] = 4'b1100; ring[7] = 4'b1000;
        bad_codes[0] = 4'b0010; bad_codes[1] = 4'b0100; bad_codes[2] = 4'b0101;
        bad_codes[3] = 4'b0110; bad_codes[4] = 4'b1001; bad_codes[5] = 4'b1010;
        bad_codes[6] = 4'b1011; bad_codes[7] = 4'b1101;
    end

    function automatic int find_phase(input logic [3:0] c);
        for (int k = 0; k < 8; k++) if (ring[k] == c) return k;
        return -1;
    endfunction

    function automatic exp_t model_step(input bit r, input bit v, input logic [3:0] c);
        exp_t e;
        int   idx;
        bit   err;
        bit   pv;
        err = 1'b0;
        pv  = 1'b0;
        if (r) begin
            m_ref = 0; m_run = 0; m_errs = 0; m_phase = 0;
            m_has_ref = 1'b0; m_locked = 1'b0;
        end else if (v) begin
            idx = find_phase(c);
            if (idx < 0) begin
                err = 1'b1;
                m_has_ref = 1'b0; m_run = 0; m_locked = 1'b0;
            end else begin
                pv = 1'b1;
                m_phase = idx;
                if (m_locked) begin
                    if (idx != (m_ref + 1) % 8) begin
                        err = 1'b1; m_locked = 1'b0; m_run = 0;
                    end
                end else if (m_has_ref && idx == (m_ref + 1) % 8) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) m_locked = 1'b1;
                end else begin
                    m_run = 0;
                end
                m_ref = idx;
                m_has_ref = 1'b1;
            end
            if (err && m_errs < 255) m_errs++;
        end
        e.phase  = 3'(m_phase);
        e.pv     = pv;
        e.locked = m_locked;
        e.err    = err;
        e.cnt    = 8'(m_errs);
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: one expectation per clock, sampled 1 time unit after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("phase",       8'(bus.phase),       8'(e.phase));
            check("phase_valid", 8'(bus.phase_valid), 8'(e.pv));
            check("locked",      8'(bus.locked),      8'(e.locked));
            check("error",       8'(bus.error),       8'(e.err));
            check("err_count",   bus.err_count,       e.cnt);
        end
    end

    task automatic drive(input bit r, input bit v, input logic [3:0] c);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.code     = c;
        exp_q.push_back(model_step(r, v, c));
    endtask

    initial begin
        int r;
        total = 0;
        bad   = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.code     = 4'b0000;

        // Reset with a valid sample pending: sample discarded
        drive(1'b1, 1'b1, 4'b0011);
        drive(1'b1, 1'b1, 4'b0011);

        // Clean run to lock, then wrap through 7 -> 0
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b0, 1'b1, 4'b0111);
        drive(1'b0, 1'b1, 4'b1111);
        drive(1'b0, 1'b1, 4'b1110);
        drive(1'b0, 1'b1, 4'b1100);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0000);
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b0011);

        // Skip while locked, then relock
        drive(1'b0, 1'b1, 4'b1111);
        drive(1'b0, 1'b1, 4'b1110);
        drive(1'b0, 1'b1, 4'b1100);

        // Illegal code, then enough illegal codes to saturate the tally
        drive(1'b0, 1'b1, 4'b0101);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, bad_codes[$urandom_range(0, 7)]);

        // Gaps while locked, then reset mid-run
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b0, 1'b1, 4'b0111);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
        drive(1'b0, 1'b1, 4'b1111);
        drive(1'b1, 1'b1, 4'b1110);
        drive(1'b0, 1'b1, 4'b1100);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0000);

        // Randomized traffic biased toward in-sequence codes
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            else if (r < 20) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
            else if (r < 75) drive(1'b0, 1'b1, ring[(m_ref + 1) % 8]);
            else if (r < 88) drive(1'b0, 1'b1, ring[$urandom_range(0, 7)]);
            else             drive(1'b0, 1'b1, bad_codes[$urandom_range(0, 7)]);
        end

        drive(1'b0, 1'b0, 4'b0000);
        @(posedge clk);
        #3;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_johnson_decoder_module
